// File: rtl/bit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_addsub
// Description : Multi-cycle serial adder/subtractor, LSB-first, DIGIT bits per
//               clock, with a one-cycle done pulse. Optional macro OVF_EN adds
//               the signed-overflow output o_ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c_out
`ifdef OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int              c_NDIG = WIDTH / DIGIT;
    localparam int              c_CW   = $clog2(c_NDIG + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;

    logic [DIGIT:0]   w_dsum;
    logic [DIGIT-1:0] w_digit;
    logic             w_carry;
    logic [WIDTH-1:0] w_r_next;
    logic             w_accept;

    assign w_dsum   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, r_carry};
    assign w_digit  = w_dsum[DIGIT-1:0];
    assign w_carry  = w_dsum[DIGIT];
    assign w_accept = i_start && (r_state != S_RUN);

    // The new digit enters at the top; with DIGIT==WIDTH it is the whole word.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign w_r_next = w_digit;
        end else begin : g_part
            assign w_r_next = {w_digit, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sum   <= '0;
            o_c_out <= 1'b0;
`ifdef OVF_EN
            o_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_r_next;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_sum   <= w_r_next;
                        o_c_out <= w_carry;
`ifdef OVF_EN
                        // On the last digit the low bits of r_a/r_b hold the operand MSBs.
                        o_ovf   <= (r_a[DIGIT-1] == r_b[DIGIT-1]) &&
                                   (w_digit[DIGIT-1] != r_a[DIGIT-1]);
`endif
                    end
                end
                default: begin
                    o_done <= 1'b0;
                    if (w_accept) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub ? ~i_c_in : i_c_in;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        o_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_addsub
// Description : Directed bench for bit_serial_addsub (8/1 and 16/4 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_addsub;

    logic        clk;
    logic        rst_n;

    logic        s8_start, s8_cin, s8_sub;
    logic [7:0]  s8_a, s8_b;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        s16_start, s16_cin, s16_sub;
    logic [15:0] s16_a, s16_b;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

`ifdef OVF_EN
    logic        ovf8, ovf16;
`endif

    int n_pass  = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit_serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (s8_start),
        .i_a     (s8_a),
        .i_b     (s8_b),
        .i_c_in  (s8_cin),
        .i_sub   (s8_sub),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_sum   (sum8),
        .o_c_out (cout8)
`ifdef OVF_EN
        ,
        .o_ovf   (ovf8)
`endif
    );

    bit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (s16_start),
        .i_a     (s16_a),
        .i_b     (s16_b),
        .i_c_in  (s16_cin),
        .i_sub   (s16_sub),
        .o_busy  (busy16),
        .o_done  (done16),
        .o_sum   (sum16),
        .o_c_out (cout16)
`ifdef OVF_EN
        ,
        .o_ovf   (ovf16)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec8_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Applies one operation from a negedge; returns edges from accept to done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, output int lat);
        @(negedge clk);
        s8_a = a; s8_b = b; s8_cin = cin; s8_sub = sub; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        wait_done8(lat);
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done8) break;
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, output int lat);
        @(negedge clk);
        s16_a = a; s16_b = b; s16_cin = cin; s16_sub = sub; s16_start = 1'b1;
        @(posedge clk); #1;
        s16_start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done16) break;
        end
    endtask

    vec8_t vecs[10];

    initial begin
        int lat;
        int seen_done;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0};
        vecs[5] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[8] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[9] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};

        rst_n = 1'b0;
        s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0; s8_sub = 1'b0;
        s16_start = 1'b0; s16_a = '0; s16_b = '0; s16_cin = 1'b0; s16_sub = 1'b0;
        #13;
        chk("reset_busy", {31'b0, busy8}, 32'd0);
        chk("reset_done", {31'b0, done8}, 32'd0);
        chk("reset_sum",  {24'b0, sum8}, 32'd0);
        chk("reset_cout", {31'b0, cout8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd8);
            chk($sformatf("v%0d_sum", i), {24'b0, sum8}, {24'b0, vecs[i].sum});
            chk($sformatf("v%0d_cout", i), {31'b0, cout8}, {31'b0, vecs[i].cout});
`ifdef OVF_EN
            chk($sformatf("v%0d_ovf", i), {31'b0, ovf8}, {31'b0, vecs[i].ovf});
`endif
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {31'b0, done8}, 32'd0);
            chk($sformatf("v%0d_sum_hold", i), {24'b0, sum8}, {24'b0, vecs[i].sum});
        end

        // start while busy must be ignored
        @(negedge clk);
        s8_a = 8'h5A; s8_b = 8'h3C; s8_cin = 1'b0; s8_sub = 1'b0; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        chk("run_busy", {31'b0, busy8}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        s8_a = 8'hFF; s8_b = 8'hFF; s8_cin = 1'b1; s8_sub = 1'b1; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        wait_done8(lat);
        chk("ignore_latency", lat + 3, 32'd8);
        chk("ignore_sum", {24'b0, sum8}, 32'h96);

        // back-to-back: start accepted in the DONE cycle
        s8_a = 8'h20; s8_b = 8'h10; s8_cin = 1'b0; s8_sub = 1'b1; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        chk("b2b_busy", {31'b0, busy8}, 32'd1);
        chk("b2b_done_low", {31'b0, done8}, 32'd0);
        chk("b2b_prev_hold", {24'b0, sum8}, 32'h96);
        wait_done8(lat);
        chk("b2b_latency", lat, 32'd8);
        chk("b2b_sum", {24'b0, sum8}, 32'h10);
        chk("b2b_cout", {31'b0, cout8}, 32'd1);

        // reset mid-RUN aborts with no done pulse
        run8(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        @(negedge clk);
        s8_a = 8'h01; s8_b = 8'h01; s8_start = 1'b1; s8_sub = 1'b0;
        @(posedge clk); #1;
        s8_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy8}, 32'd0);
        chk("abort_sum", {24'b0, sum8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen_done++;
        end
        chk("abort_no_done", seen_done, 32'd0);

        // 16-bit, 4 bits per clock
        run16(16'h1234, 16'hEDCC, 1'b0, 1'b0, lat);
        chk("w16_latency", lat, 32'd4);
        chk("w16_sum", {16'b0, sum16}, 32'h0000);
        chk("w16_cout", {31'b0, cout16}, 32'd1);
        run16(16'hABCD, 16'h1111, 1'b0, 1'b0, lat);
        chk("w16b_sum", {16'b0, sum16}, 32'hBCDE);
        chk("w16b_cout", {31'b0, cout16}, 32'd0);
        run16(16'h1000, 16'h0001, 1'b0, 1'b1, lat);
        chk("w16c_sum", {16'b0, sum16}, 32'h0FFF);
        chk("w16c_cout", {31'b0, cout16}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
